// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory request responder between memory stage and RAM port
// Optional REQ-state timeout abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_responder #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dhit,
   output logic [DATA_W-1:0] dload,
   output logic              derr,
   output logic              busy,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ramready
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_ERR} state_t;

   state_t            r_state;
   logic              r_ren;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_stale;
   logic              r_dhit;
   logic              r_derr;
   logic [DATA_W-1:0] r_dload;
   logic              r_ram_ren;
   logic              r_ram_wen;

   logic w_req;
   logic w_same;
   logic w_accept;
   logic w_bad;

   // A completed request stays stale until the requester drops it or changes op/address.
   assign w_req    = dREN | dWEN;
   assign w_same   = (daddr == r_addr) && (dREN == r_ren) && (dWEN == r_wen);
   assign w_accept = w_req && !(r_stale && w_same);
   assign w_bad    = (dREN & dWEN) | (daddr[1:0] != 2'b00);

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] r_cnt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_ren     <= 1'b0;
         r_wen     <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_stale   <= 1'b0;
         r_dhit    <= 1'b0;
         r_derr    <= 1'b0;
         r_dload   <= '0;
         r_ram_ren <= 1'b0;
         r_ram_wen <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_dhit <= 1'b0;
         r_derr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_req || !w_same) r_stale <= 1'b0;
               if (w_accept) begin
                  r_ren  <= dREN;
                  r_wen  <= dWEN;
                  r_addr <= daddr;
                  r_data <= dstore;
                  if (w_bad) begin
                     r_state <= S_ERR;
                     r_derr  <= 1'b1;
                  end else begin
                     r_state   <= S_REQ;
                     r_ram_ren <= dREN;
                     r_ram_wen <= dWEN;
`ifdef DMEM_TIMEOUT_EN
                     r_cnt     <= '0;
`endif
                  end
               end
            end
            S_REQ: begin
               if (ramready) begin
                  r_ram_ren <= 1'b0;
                  r_ram_wen <= 1'b0;
                  r_dhit    <= 1'b1;
                  r_state   <= S_RESP;
                  if (r_ren) r_dload <= ramload;
               end
`ifdef DMEM_TIMEOUT_EN
               // ramready on the limit cycle takes the branch above and completes normally.
               else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_ram_ren <= 1'b0;
                  r_ram_wen <= 1'b0;
                  r_derr    <= 1'b1;
                  r_state   <= S_ERR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            S_RESP, S_ERR: begin
               r_state <= S_IDLE;
               r_stale <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign dhit     = r_dhit;
   assign derr     = r_derr;
   assign dload    = r_dload;
   assign busy     = (r_state != S_IDLE);
   assign ramREN   = r_ram_ren;
   assign ramWEN   = r_ram_wen;
   assign ramaddr  = r_addr;
   assign ramstore = r_data;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the data-memory request interface driven by the pipeline memory stage.
- Accepts level-held read/write requests (dREN/dWEN, daddr, dstore) and forwards them to a variable-latency RAM port.
- Returns a one-cycle dhit with load data, and flags misaligned or illegal requests on derr.
- Sits between the memory-stage latch and the RAM/memory controller.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- TIMEOUT, 255, maximum REQ-state wait cycles before abort (used only with the optional feature)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- dREN  in  1  read request from memory stage, level-held
- dWEN  in  1  write request from memory stage, level-held
- daddr  in  ADDR_W  request byte address
- dstore  in  DATA_W  store data
- dhit  out  1  one-cycle completion pulse
- dload  out  DATA_W  load data; valid from dhit, held until the next read completes
- derr  out  1  one-cycle error pulse
- busy  out  1  high in any state other than IDLE
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ramready=1
- ramready  in  1  RAM access complete this cycle

Behaviour:
- Reset: asynchronous on RST=1.
  - State goes to IDLE; every output becomes 0, including dload.
  - Latched op, address and data registers clear; stale flag clears.
- States: IDLE, REQ, RESP, ERR.
- IDLE, when a request is accepted (dREN|dWEN, stale=0):
  - Latch op, daddr and dstore.
  - If dREN&dWEN, or daddr[1:0]!=0: go to ERR.
  - Otherwise: go to REQ.
- REQ:
  - ramREN/ramWEN driven from the latched op.
  - ramaddr/ramstore driven from the latched registers; requester changes are ignored.
  - On ramready=1: for a read, capture ramload into dload; deassert the RAM strobes next cycle; go to RESP.
- RESP:
  - dhit=1 for exactly one cycle, then IDLE.
  - stale is set, recording the completed op and address.
- ERR:
  - derr=1 for exactly one cycle; dhit stays 0; no RAM strobe is ever asserted.
  - Then IDLE, with stale set as in RESP.
- Stale rule: stale clears when dREN=dWEN=0, or when daddr or the op differs from the recorded one.
  - A request is accepted in the same cycle its inputs differ.
  - This prevents re-issuing a held request after dhit while still allowing back-to-back accesses to different addresses.
- Latency: request seen in IDLE at cycle 0 -> ramREN/ramWEN from cycle 1.
  - With ramready at cycle k>=1, dhit occurs at cycle k+1.
  - Minimum request-to-dhit latency is 2 cycles.
- Writes leave dload unchanged.
- Reset asserted mid-REQ aborts the access: strobes drop immediately and no dhit is issued.
- ramready outside REQ is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ramready.
  - When the counter reaches TIMEOUT: drop the strobes and go to ERR (derr pulse, no dhit, dload unchanged).
  - ramready in the same cycle as the limit wins, giving normal completion.
- Undefined: no counter; REQ waits on ramready indefinitely.

Test Plan:
- Read: dREN=1, daddr=0x100, ramready high on the 3rd REQ cycle with ramload=0xDEADBEEF -> ramREN high for 3 cycles, dhit pulse 1 cycle, dload=0xDEADBEEF, then no re-issue while dREN stays held at 0x100.
- Back-to-back: after the read, daddr changes to 0x104 with dREN still high, dWEN=0 -> new ramREN the next cycle, second dhit; then dWEN=1, dREN=0, dstore=0x12345678 -> ramWEN with ramstore=0x12345678, dload unchanged.
- Errors: daddr=0x102 with dREN=1 -> derr pulse, ramREN never asserted, dhit=0; dREN=dWEN=1 at 0x200 -> same derr response.
- Reset mid-REQ: assert RST while ramREN=1 -> all outputs 0 asynchronously; after release with dREN held, the request is re-accepted.
- Timeout with DMEM_TIMEOUT_EN, TIMEOUT=4, ramready=0 -> derr after 4 REQ cycles, no dhit. Without the macro -> busy stays high indefinitely, and ramready at cycle 20 completes normally.
- Tie: ramready on the exact timeout cycle -> dhit, no derr.
